// File: rtl/can_pkg.sv
`default_nettype none
// ============================================================================
// Package     : can_pkg
// Description : Shared definitions for the CAN TX frame fetch path. It holds
//               the bit positions of the 128-bit TX FIFO word, the largest
//               legal DLC, the fetch FSM state type and the held-frame
//               record. It also provides a helper that clamps a DLC value.
// Revision    : 1.0 - initial release
// ============================================================================
package can_pkg;

   // TX FIFO word layout
   localparam int CAN_WORD_W   = 128;
   localparam int CAN_ID_MSB   = 127;
   localparam int CAN_ID_LSB   = 99;
   localparam int CAN_IDE_BIT  = 98;
   localparam int CAN_RTR_BIT  = 97;
   localparam int CAN_DLC_MSB  = 96;
   localparam int CAN_DLC_LSB  = 93;
   localparam int CAN_RSVD_MSB = 92;
   localparam int CAN_RSVD_LSB = 64;
   localparam int CAN_DATA_MSB = 63;
   localparam int CAN_DATA_LSB = 0;

   localparam int CAN_ID_W     = CAN_ID_MSB - CAN_ID_LSB + 1;
   localparam int CAN_DLC_W    = CAN_DLC_MSB - CAN_DLC_LSB + 1;
   localparam int CAN_DATA_W   = CAN_DATA_MSB - CAN_DATA_LSB + 1;

   // Classic CAN carries at most 8 data bytes. DLC codes 9..15 still mean 8.
   localparam logic [CAN_DLC_W-1:0] CAN_MAX_DLC = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OFFER  = 2'd1,
      ST_ACTIVE = 2'd2
   } can_tx_state_e;

   typedef struct packed {
      logic [CAN_ID_W-1:0]   id;
      logic                  ide;
      logic                  rtr;
      logic [CAN_DLC_W-1:0]  dlc;
      logic [CAN_DATA_W-1:0] data;
   } can_frame_t;

   function automatic logic [CAN_DLC_W-1:0] can_clamp_dlc(input logic [CAN_DLC_W-1:0] dlc);
      return (dlc > CAN_MAX_DLC) ? CAN_MAX_DLC : dlc;
   endfunction

endpackage
`default_nettype wire

// File: rtl/can_frame_unpack.sv
`default_nettype none
// ============================================================================
// Module      : can_frame_unpack
// Description : Combinational split of a 128-bit TX FIFO word into CAN frame
//               fields. The DLC is clamped to 8. The reserved bits are
//               discarded.
// Ports       : i_word  - raw FIFO word
//               o_id    - 29-bit identifier (11-bit IDs sit in the low bits)
//               o_ide   - extended identifier flag
//               o_rtr   - remote request flag
//               o_dlc   - clamped data length code
//               o_data  - payload, byte 0 in [63:56]
// Revision    : 1.0 - initial release
// ============================================================================
module can_frame_unpack
   import can_pkg::*;
(
   input  logic [CAN_WORD_W-1:0] i_word,
   output logic [CAN_ID_W-1:0]   o_id,
   output logic                  o_ide,
   output logic                  o_rtr,
   output logic [CAN_DLC_W-1:0]  o_dlc,
   output logic [CAN_DATA_W-1:0] o_data
);

   // Reserved field is carried in the word but has no meaning for transmit.
   logic [CAN_RSVD_MSB-CAN_RSVD_LSB:0] w_unused_rsvd;
   assign w_unused_rsvd = i_word[CAN_RSVD_MSB:CAN_RSVD_LSB];

   assign o_id   = i_word[CAN_ID_MSB:CAN_ID_LSB];
   assign o_ide  = i_word[CAN_IDE_BIT];
   assign o_rtr  = i_word[CAN_RTR_BIT];
   assign o_dlc  = can_clamp_dlc(i_word[CAN_DLC_MSB:CAN_DLC_LSB]);
   // The payload passes through untouched, even for remote frames.
   assign o_data = i_word[CAN_DATA_MSB:CAN_DATA_LSB];

endmodule
`default_nettype wire

// File: rtl/can_tx_frame_fetch.sv
`default_nettype none
// ============================================================================
// Module      : can_tx_frame_fetch
// Description : Pops frames from a first-word-fall-through TX FIFO, holds
//               each one and offers it to the CAN bit transmitter with a
//               valid/ready handshake. A failed attempt is retried up to
//               MAX_RETRIES times. After that, or on abort, the frame is
//               dropped.
// Ports       : i_sys_clk, i_reset_n       - clock, async active-low reset
//               i_fifo_empty/i_fifo_r_data - FIFO status and head word
//               o_fifo_r_en                - FIFO pop strobe (combinational)
//               o_tx_valid/i_tx_ready      - frame offer handshake
//               o_tx_id/ide/rtr/dlc/data   - held frame fields
//               i_tx_done/i_tx_success     - attempt result
//               i_abort                    - cancel current frame
//               o_frame_sent/o_frame_dropped - 1-cycle result pulses
//               o_retry_cnt, o_busy        - status
// Revision    : 1.0 - initial release
// ============================================================================
module can_tx_frame_fetch
   import can_pkg::*;
#(
   parameter int MAX_RETRIES = 3
)
(
   input  logic                               i_sys_clk,
   input  logic                               i_reset_n,
   input  logic                               i_fifo_empty,
   input  logic [CAN_WORD_W-1:0]              i_fifo_r_data,
   output logic                               o_fifo_r_en,
   output logic                               o_tx_valid,
   input  logic                               i_tx_ready,
   output logic [CAN_ID_W-1:0]                o_tx_id,
   output logic                               o_tx_ide,
   output logic                               o_tx_rtr,
   output logic [CAN_DLC_W-1:0]               o_tx_dlc,
   output logic [CAN_DATA_W-1:0]              o_tx_data,
   input  logic                               i_tx_done,
   input  logic                               i_tx_success,
   input  logic                               i_abort,
   output logic                               o_frame_sent,
   output logic                               o_frame_dropped,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   o_retry_cnt,
   output logic                               o_busy
);

   localparam int                 c_cnt_w       = $clog2(MAX_RETRIES + 1);
   localparam logic [c_cnt_w-1:0] c_max_retries = c_cnt_w'(MAX_RETRIES);

   can_tx_state_e         r_state;
   can_tx_state_e         w_state_nxt;
   can_frame_t            r_hold;
   can_frame_t            w_unpacked;
   logic [c_cnt_w-1:0]    r_retry_cnt;
   logic                  r_tx_valid;
   logic                  r_frame_sent;
   logic                  r_frame_dropped;
   logic                  r_busy;

   logic                  w_done_ok;
   logic                  w_done_fail;
   logic                  w_retry_left;
   logic                  w_fifo_r_en;
   logic                  w_sent;
   logic                  w_drop;
   logic                  w_retry_inc;

   // ------------------------------------------------------------------
   // Word unpack, applied to the FIFO head so the hold register already
   // contains clamped fields when the pop edge occurs.
   // ------------------------------------------------------------------
   can_frame_unpack u_unpack (
      .i_word (i_fifo_r_data),
      .o_id   (w_unpacked.id),
      .o_ide  (w_unpacked.ide),
      .o_rtr  (w_unpacked.rtr),
      .o_dlc  (w_unpacked.dlc),
      .o_data (w_unpacked.data)
   );

   assign w_done_ok    = i_tx_done &  i_tx_success;
   assign w_done_fail  = i_tx_done & ~i_tx_success;
   assign w_retry_left = (r_retry_cnt < c_max_retries);

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state. In ACTIVE, a successful completion wins over abort,
   // and abort wins over a failed completion. A failed attempt that
   // coincides with abort therefore never retries.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!i_fifo_empty) begin
               w_state_nxt = ST_OFFER;
            end
         end
         ST_OFFER: begin
            if (i_abort) begin
               w_state_nxt = ST_IDLE;
            end else if (i_tx_ready) begin
               w_state_nxt = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (w_done_ok || i_abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_done_fail) begin
               w_state_nxt = w_retry_left ? ST_OFFER : ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM outputs (combinational strobes)
   // ------------------------------------------------------------------
   always_comb begin
      w_fifo_r_en = 1'b0;
      w_sent      = 1'b0;
      w_drop      = 1'b0;
      w_retry_inc = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // The pop strobe is gated with reset. While reset is held the
            // FSM cannot leave IDLE, so no word may be consumed.
            w_fifo_r_en = ~i_fifo_empty & i_reset_n;
         end
         ST_OFFER: begin
            w_drop = i_abort;
         end
         ST_ACTIVE: begin
            if (w_done_ok) begin
               w_sent = 1'b1;
            end else if (i_abort) begin
               w_drop = 1'b1;
            end else if (w_done_fail) begin
               w_retry_inc = w_retry_left;
               w_drop      = ~w_retry_left;
            end
         end
         default: begin
            w_fifo_r_en = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_hold          <= '0;
         r_retry_cnt     <= '0;
         r_tx_valid      <= 1'b0;
         r_frame_sent    <= 1'b0;
         r_frame_dropped <= 1'b0;
         r_busy          <= 1'b0;
      end else begin
         if (w_fifo_r_en) begin
            r_hold      <= w_unpacked;
            r_retry_cnt <= '0;
         end else if (w_retry_inc && (r_retry_cnt != c_max_retries)) begin
            r_retry_cnt <= r_retry_cnt + c_cnt_w'(1);
         end
         r_tx_valid      <= (w_state_nxt == ST_OFFER);
         r_busy          <= (w_state_nxt != ST_IDLE);
         r_frame_sent    <= w_sent;
         r_frame_dropped <= w_drop;
      end
   end

   assign o_fifo_r_en     = w_fifo_r_en;
   assign o_tx_valid      = r_tx_valid;
   assign o_tx_id         = r_hold.id;
   assign o_tx_ide        = r_hold.ide;
   assign o_tx_rtr        = r_hold.rtr;
   assign o_tx_dlc        = r_hold.dlc;
   assign o_tx_data       = r_hold.data;
   assign o_frame_sent    = r_frame_sent;
   assign o_frame_dropped = r_frame_dropped;
   assign o_retry_cnt     = r_retry_cnt;
   assign o_busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_can_tx_frame_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_can_tx_frame_fetch
// Description : Directed self-checking bench for can_tx_frame_fetch. A small
//               FWFT FIFO model feeds the DUT. Expected values are written
//               out by hand for each scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_can_tx_frame_fetch;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fifo_empty;
   logic [127:0]  fifo_data;
   logic          r_en;
   logic          tx_valid;
   logic          tx_ready;
   logic [28:0]   tx_id;
   logic          tx_ide;
   logic          tx_rtr;
   logic [3:0]    tx_dlc;
   logic [63:0]   tx_data;
   logic          tx_done;
   logic          tx_success;
   logic          abort;
   logic          sent;
   logic          dropped;
   logic [1:0]    retry_cnt;
   logic          busy;

   logic [127:0]  mem [0:15];
   int            wr_ptr    = 0;
   int            rd_ptr    = 0;
   int            pops      = 0;
   int            underflow = 0;
   int            sent_cnt  = 0;
   int            drop_cnt  = 0;
   int            total     = 0;
   int            bad       = 0;

   always #5 clk = ~clk;

   assign fifo_empty = (rd_ptr == wr_ptr);
   assign fifo_data  = mem[rd_ptr[3:0]];

   can_tx_frame_fetch #(.MAX_RETRIES(3)) dut (
      .i_sys_clk       (clk),
      .i_reset_n       (rst_n),
      .i_fifo_empty    (fifo_empty),
      .i_fifo_r_data   (fifo_data),
      .o_fifo_r_en     (r_en),
      .o_tx_valid      (tx_valid),
      .i_tx_ready      (tx_ready),
      .o_tx_id         (tx_id),
      .o_tx_ide        (tx_ide),
      .o_tx_rtr        (tx_rtr),
      .o_tx_dlc        (tx_dlc),
      .o_tx_data       (tx_data),
      .i_tx_done       (tx_done),
      .i_tx_success    (tx_success),
      .i_abort         (abort),
      .o_frame_sent    (sent),
      .o_frame_dropped (dropped),
      .o_retry_cnt     (retry_cnt),
      .o_busy          (busy)
   );

   // FIFO pop side and pulse counters
   always @(posedge clk) begin
      if (r_en) begin
         if (fifo_empty) begin
            underflow <= underflow + 1;
         end else begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
         end
      end
      if (sent)    sent_cnt <= sent_cnt + 1;
      if (dropped) drop_cnt <= drop_cnt + 1;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] mk(input logic [28:0] id, input logic ide, input logic rtr,
                                       input logic [3:0] dlc, input logic [63:0] data);
      // Reserved bits are deliberately non-zero. The DUT must ignore them.
      return {id, ide, rtr, dlc, 29'h15A5A5A5, data};
   endfunction

   task automatic push(input logic [127:0] w);
      mem[wr_ptr[3:0]] = w;
      wr_ptr++;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (tx_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check(tag, tx_valid, 1'b1);
   endtask

   task automatic fail_attempt(input logic [1:0] exp_cnt);
      tx_done = 1'b1; tx_success = 1'b0;
      step();
      tx_done = 1'b0;
      check("retry_valid", tx_valid, 1'b1);
      check("retry_cnt", retry_cnt, exp_cnt);
      check("retry_no_drop", dropped, 1'b0);
      step();
      check("retry_active", tx_valid, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      rst_n = 1'b0; tx_ready = 1'b1; tx_done = 1'b0; tx_success = 1'b0; abort = 1'b0;

      // ---------------- reset and single successful frame ----------------
      push(mk(29'h1ABCDEF, 1'b1, 1'b0, 4'd4, 64'h11223344_00000000));
      step(); step();
      check("rst_r_en", r_en, 1'b0);
      check("rst_valid", tx_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_retry", retry_cnt, 2'd0);
      check("rst_id", tx_id, 29'h0);
      check("rst_dlc", tx_dlc, 4'h0);
      check("rst_data", tx_data, 64'h0);
      check("rst_sent", sent, 1'b0);
      rst_n = 1'b1;
      #1;
      check("pop_strobe", r_en, 1'b1);
      step();
      check("pop_once", r_en, 1'b0);
      check("t1_valid", tx_valid, 1'b1);
      check("t1_busy", busy, 1'b1);
      check("t1_id", tx_id, 29'h1ABCDEF);
      check("t1_ide", tx_ide, 1'b1);
      check("t1_rtr", tx_rtr, 1'b0);
      check("t1_dlc", tx_dlc, 4'd4);
      check("t1_data", tx_data, 64'h11223344_00000000);
      check("t1_empty", fifo_empty, 1'b1);
      step();
      check("t1_active_valid", tx_valid, 1'b0);
      check("t1_active_id", tx_id, 29'h1ABCDEF);
      tx_done = 1'b1; tx_success = 1'b1;
      step();
      tx_done = 1'b0;
      check("t1_sent", sent, 1'b1);
      check("t1_idle", busy, 1'b0);
      step();
      check("t1_sent_pulse", sent, 1'b0);
      check("t1_sent_cnt", sent_cnt, 1);
      check("t1_pops", pops, 1);

      // ---------------- retries exhausted ----------------
      push(mk(29'h0000555, 1'b0, 1'b0, 4'd8, 64'h0102030405060708));
      wait_valid("t2_valid");
      check("t2_retry0", retry_cnt, 2'd0);
      step();
      check("t2_active", tx_valid, 1'b0);
      fail_attempt(2'd1);
      fail_attempt(2'd2);
      fail_attempt(2'd3);
      tx_done = 1'b1; tx_success = 1'b0;
      step();
      tx_done = 1'b0;
      check("t2_dropped", dropped, 1'b1);
      check("t2_no_reoffer", tx_valid, 1'b0);
      check("t2_retry_sat", retry_cnt, 2'd3);
      check("t2_idle", busy, 1'b0);
      step();
      check("t2_drop_pulse", dropped, 1'b0);
      check("t2_sent_cnt", sent_cnt, 1);
      check("t2_drop_cnt", drop_cnt, 1);

      // ---------------- dlc clamp, stall, done ignored in OFFER ----------------
      tx_ready = 1'b0;
      push(mk(29'h0000123, 1'b0, 1'b1, 4'hF, 64'hDEADBEEF_CAFEF00D));
      wait_valid("t3_valid");
      for (int i = 0; i < 10; i++) begin
         check("t3_stall_valid", tx_valid, 1'b1);
         check("t3_stall_dlc", tx_dlc, 4'd8);
         check("t3_stall_id", tx_id, 29'h0000123);
         check("t3_stall_data", tx_data, 64'hDEADBEEF_CAFEF00D);
         tx_done = (i == 3); tx_success = (i == 3);
         step();
      end
      tx_done = 1'b0; tx_success = 1'b0;
      check("t3_rtr", tx_rtr, 1'b1);
      check("t3_done_ignored", sent_cnt, 1);
      tx_ready = 1'b1;
      step();
      check("t3_active", tx_valid, 1'b0);
      check("t3_active_dlc", tx_dlc, 4'd8);

      // ---------------- same-cycle priority ----------------
      abort = 1'b1; tx_done = 1'b1; tx_success = 1'b1;
      step();
      abort = 1'b0; tx_done = 1'b0; tx_success = 1'b0;
      check("t4_ok_sent", sent, 1'b1);
      check("t4_ok_nodrop", dropped, 1'b0);
      step();
      push(mk(29'h1FFFFFFF, 1'b1, 1'b0, 4'd2, 64'hAA55));
      wait_valid("t4_valid");
      step();
      abort = 1'b1; tx_done = 1'b1; tx_success = 1'b0;
      step();
      abort = 1'b0; tx_done = 1'b0;
      check("t4_fail_drop", dropped, 1'b1);
      check("t4_fail_nosent", sent, 1'b0);
      check("t4_fail_noretry", retry_cnt, 2'd0);
      check("t4_fail_valid", tx_valid, 1'b0);
      step();
      check("t4_sent_cnt", sent_cnt, 2);
      check("t4_drop_cnt", drop_cnt, 2);

      // ---------------- reset mid-frame ----------------
      push(mk(29'h0000AAA, 1'b0, 1'b0, 4'd1, 64'h1));
      push(mk(29'h0000BBB, 1'b0, 1'b0, 4'd3, 64'h2));
      wait_valid("t5_valid_a");
      check("t5_id_a", tx_id, 29'h0000AAA);
      step();
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", tx_valid, 1'b0);
      check("t5_rst_busy", busy, 1'b0);
      check("t5_rst_id", tx_id, 29'h0);
      check("t5_rst_r_en", r_en, 1'b0);
      step(); step();
      check("t5_rst_nosent", sent_cnt, 2);
      check("t5_rst_nodrop", drop_cnt, 2);
      rst_n = 1'b1;
      #1;
      check("t5_pop_b", r_en, 1'b1);
      wait_valid("t5_valid_b");
      check("t5_id_b", tx_id, 29'h0000BBB);
      check("t5_dlc_b", tx_dlc, 4'd3);
      step();
      tx_done = 1'b1; tx_success = 1'b1;
      step();
      tx_done = 1'b0; tx_success = 1'b0;
      check("t5_sent_b", sent, 1'b1);
      step();
      check("t5_sent_cnt", sent_cnt, 3);
      check("t5_pops", pops, 6);
      check("t5_empty", fifo_empty, 1'b1);
      check("no_underflow", underflow, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
